// File: rtl/merge_two_sorted.sv
// Streaming two-way merger: combines two ascending-sorted packet streams into one
// ascending packet per input pair, with a sticky flag for out-of-order data.
module merge_two_sorted #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             sort_err
);

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_t;

  state_t           state;
  logic             load_en;
  logic             take_a;
  logic             take_b;
  logic             load;
  logic [WIDTH-1:0] ld_data;
  logic             ld_last;
  logic [WIDTH-1:0] prev_data;
  logic             prev_valid;

  // Selection stage: decide which input (if any) moves into the output register
  always_comb begin
    take_a  = 1'b0;
    take_b  = 1'b0;
    load_en = !out_valid || out_ready;
    if (rst_n && load_en) begin
      case (state)
        MERGE: begin
          if (a_valid && b_valid) begin
            if (a_data <= b_data) take_a = 1'b1;
            else                  take_b = 1'b1;
          end
        end
        DRAIN_A: take_a = a_valid;
        DRAIN_B: take_b = b_valid;
        default: begin
          take_a = 1'b0;
          take_b = 1'b0;
        end
      endcase
    end
  end

  assign a_ready = take_a;
  assign b_ready = take_b;
  assign load    = take_a || take_b;
  assign ld_data = take_a ? a_data : b_data;
  // Only the drain states close a merged packet
  assign ld_last = ((state == DRAIN_A) && take_a && a_last) ||
                   ((state == DRAIN_B) && take_b && b_last);

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MERGE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      sort_err   <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= ld_data;
        out_last   <= ld_last;
        prev_valid <= !ld_last;
        if (prev_valid && (ld_data < prev_data)) sort_err <= 1'b1;
        case (state)
          MERGE: begin
            if (take_a && a_last)      state <= DRAIN_B;
            else if (take_b && b_last) state <= DRAIN_A;
          end
          DRAIN_A: if (a_last) state <= MERGE;
          DRAIN_B: if (b_last) state <= MERGE;
          default: state <= MERGE;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // prev_data is only meaningful while prev_valid is set, so it needs no reset
  always_ff @(posedge clk) begin
    if (load) prev_data <= ld_data;
  end

endmodule

// File: tb/tb_merge_two_sorted.sv
// Bench for merge_two_sorted: directed packet pairs checked against a queue-based
// merge model every cycle, plus literal expectations for selected sequences.
module tb_merge_two_sorted;

  typedef struct {
    logic [3:0] d;
    logic       l;
  } src_t;

  typedef struct {
    logic [3:0] d;
    logic       l;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_ready, a_last;
  logic [3:0] a_data;
  logic       b_valid, b_ready, b_last;
  logic [3:0] b_data;
  logic       out_valid, out_ready, out_last, sort_err;
  logic [3:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;

  src_t       a_src[$];
  src_t       b_src[$];
  exp_t       exp_q[$];
  logic [3:0] pa[$];
  logic [3:0] pb[$];
  logic [3:0] log_d[$];
  logic       log_l[$];
  logic [3:0] lit_d[$];
  logic       lit_l[$];
  logic       rdy_pat[$];

  logic       a_fire = 1'b0;
  logic       b_fire = 1'b0;
  logic       b_en = 1'b1;
  logic       pend_v = 1'b0;
  logic [3:0] pend_d = '0;
  logic       cur_err = 1'b0;
  logic       model_err = 1'b0;
  logic       mprev_v = 1'b0;
  logic [3:0] mprev = '0;

  merge_two_sorted #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sort_err(sort_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, got, want, $time);
    end
  endtask

  // Model: plain two-pointer merge (tie to A) with per-packet order tracking
  task automatic queue_pair();
    int   i = 0;
    int   j = 0;
    int   n;
    exp_t e;
    foreach (pa[k]) a_src.push_back('{d: pa[k], l: (k == pa.size() - 1)});
    foreach (pb[k]) b_src.push_back('{d: pb[k], l: (k == pb.size() - 1)});
    n = pa.size() + pb.size();
    for (int k = 0; k < n; k++) begin
      if (j >= pb.size() || (i < pa.size() && pa[i] <= pb[j])) begin
        e.d = pa[i];
        i++;
      end else begin
        e.d = pb[j];
        j++;
      end
      e.l = (k == n - 1);
      if (mprev_v && e.d < mprev) model_err = 1'b1;
      mprev   = e.d;
      mprev_v = !e.l;
      e.e     = model_err;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || a_src.size() != 0 || b_src.size() != 0) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, int'(exp_q.size()), 0);
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, log_d.size(), lit_d.size());
    foreach (lit_d[k]) begin
      if (k < log_d.size()) begin
        check($sformatf("%s_data%0d", name, k), int'(log_d[k]), int'(lit_d[k]));
        check($sformatf("%s_last%0d", name, k), int'(log_l[k]), int'(lit_l[k]));
      end
    end
    log_d.delete();
    log_l.delete();
  endtask

  // Source drivers: advance on an observed handshake, present head of queue
  initial begin
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (a_fire && a_src.size() > 0) void'(a_src.pop_front());
      if (rst_n && a_src.size() > 0) begin
        a_valid = 1'b1; a_data = a_src[0].d; a_last = a_src[0].l;
      end else a_valid = 1'b0;
    end
  end

  initial begin
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (b_fire && b_src.size() > 0) void'(b_src.pop_front());
      if (rst_n && b_en && b_src.size() > 0) begin
        b_valid = 1'b1; b_data = b_src[0].d; b_last = b_src[0].l;
      end else b_valid = 1'b0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
      else out_ready = 1'b1;
    end
  end

  // Compare process: every cycle against the model scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_v = 1'b0;
      end else begin
        check("ready_exclusive", int'(a_ready && b_ready), 0);
        if (pend_v) begin
          check("latency_valid", int'(out_valid), 1);
          check("latency_data", int'(out_data), int'(pend_d));
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", int'(out_data), -1);
          end else begin
            check("out_data", int'(out_data), int'(exp_q[0].d));
            check("out_last", int'(out_last), int'(exp_q[0].l));
            check("sort_err", int'(sort_err), int'(exp_q[0].e));
            if (out_ready) begin
              log_d.push_back(out_data);
              log_l.push_back(out_last);
              cur_err = exp_q[0].e;
              void'(exp_q.pop_front());
            end
          end
        end else begin
          check("sort_err_idle", int'(sort_err), int'(cur_err));
        end
        pend_v = (a_valid && a_ready) || (b_valid && b_ready);
        pend_d = (a_valid && a_ready) ? a_data : b_data;
      end
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_sort_err", int'(sort_err), 0);
    #20 rst_n = 1'b1;

    // Basic interleave
    pa = '{4'd1, 4'd3, 4'd5}; pb = '{4'd2, 4'd4};
    queue_pair();
    wait_done("t1");
    lit_d = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5}; lit_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_log("t1");

    // Ties go to A first
    pa = '{4'd6, 4'd6}; pb = '{4'd6};
    queue_pair();
    wait_done("t2");
    lit_d = '{4'd6, 4'd6, 4'd6}; lit_l = '{1'b0, 1'b0, 1'b1};
    check_log("t2");

    // Drain of A with max value, then a packet restarting at zero
    pa = '{4'd15}; pb = '{4'd3, 4'd8, 4'd11};
    queue_pair();
    pa = '{4'd0}; pb = '{4'd0};
    queue_pair();
    wait_done("t3");
    lit_d = '{4'd3, 4'd8, 4'd11, 4'd15, 4'd0, 4'd0};
    lit_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    check_log("t3");
    check("t3_no_err", int'(sort_err), 0);

    // Output backpressure
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pa = '{4'd2, 4'd9}; pb = '{4'd3};
    queue_pair();
    wait_done("t4");
    lit_d = '{4'd2, 4'd3, 4'd9}; lit_l = '{1'b0, 1'b0, 1'b1};
    check_log("t4");

    // Unsorted input, then asynchronous reset mid-packet
    pa = '{4'd5, 4'd2}; pb = '{4'd7};
    queue_pair();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(out_valid && out_data == 4'd2) && cyc < 50);
    check("t5_reach_2", int'(out_data), 2);
    check("t5_err_set", int'(sort_err), 1);
    #2;
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 4'd1; b_valid = 1'b1; b_data = 4'd2;
    #1;
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_data", int'(out_data), 0);
    check("t5_rst_last", int'(out_last), 0);
    check("t5_rst_err", int'(sort_err), 0);
    check("t5_rst_a_ready", int'(a_ready), 0);
    check("t5_rst_b_ready", int'(b_ready), 0);
    exp_q.delete(); a_src.delete(); b_src.delete(); rdy_pat.delete();
    log_d.delete(); log_l.delete();
    model_err = 1'b0; mprev_v = 1'b0; cur_err = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Only A valid in MERGE: stall
    b_en = 1'b0;
    pa = '{4'd1}; pb = '{4'd4};
    queue_pair();
    repeat (4) begin
      @(negedge clk);
      check("t6_a_ready", int'(a_ready), 0);
      check("t6_out_valid", int'(out_valid), 0);
    end
    b_en = 1'b1;
    wait_done("t6");
    lit_d = '{4'd1, 4'd4}; lit_l = '{1'b0, 1'b1};
    check_log("t6");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_two_sorted.md
Name: merge_two_sorted

Overview:
- Streaming merger: consumes two independently ascending-sorted input streams (A, B) and emits one ascending-sorted output stream.
- Each input delivers packets terminated by *_last. One output packet is produced per pair of input packets.
- Sits downstream of the compare-and-swap sorter stages, as the consumer/assembler of their sorted runs.
- Valid/ready handshake on all three streams. Registered output. Sticky flag for out-of-order input.

Parameters:
- WIDTH, 4, data width in bits (unsigned).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  stream A element present
- a_ready  out  1  stream A element accepted this cycle
- a_data  in  WIDTH  stream A element (unsigned)
- a_last  in  1  last element of current A packet
- b_valid / b_ready / b_data / b_last  same as A, for stream B
- out_valid  out  1  output element present
- out_ready  in  1  downstream accepts output
- out_data  out  WIDTH  merged element
- out_last  out  1  last element of merged packet
- sort_err  out  1  sticky: an input or output element arrived out of ascending order

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, sort_err=0, state=MERGE, prev_valid=0. a_ready and b_ready are 0 while in reset.
- Output register loads when load_en = (!out_valid || out_ready). It holds stable while out_valid && !out_ready.
- Sources must hold data/last stable while valid && !ready. Every input packet has >=1 element.
- States:
  - MERGE: both packets open.
    - Transfer only when a_valid && b_valid && load_en.
    - Select A if a_data <= b_data (tie goes to A), else B. Only the selected ready is asserted. The other input is not consumed.
    - Selected A with a_last: go to DRAIN_B. Selected B with b_last: go to DRAIN_A.
    - out_last=0 on every MERGE transfer.
    - If only one input is valid, stall. No transfer and no ready asserted.
  - DRAIN_A: B packet done.
    - a_ready = load_en. Pass A elements through.
    - On a_last transfer: out_last=1, go to MERGE.
    - b_ready=0.
  - DRAIN_B: mirror of DRAIN_A.
- a_ready/b_ready are combinational from state, valid, data and load_en. Never assert a ready without a transfer.
- Latency: element accepted in cycle N appears on out_* in cycle N+1. Throughput 1 element/cycle when out_ready is held high.
- Order check:
  - Keep prev = last data loaded into the output register, with prev_valid.
  - If a load has data < prev, set sort_err. This is caused by an unsorted input.
  - prev_valid clears after a load with out_last=1, so a new packet may start lower.
  - sort_err is cleared only by reset. Data still passes through when sort_err is set.
- Ties across streams: both elements are emitted, A first. Equal values are not errors.
- Backpressure: with out_ready low and out_valid high, no inputs are accepted and state does not change.
- Reset mid-packet: partial packet discarded, state returns to MERGE, no out_last emitted.
- Max value (all ones) and zero need no special casing. Compare is full-width unsigned, no wrap.

Test Plan:
- A={1,3,5 last}, B={2,4 last}, out_ready=1 -> out 1,2,3,4,5. out_last only on 5. Each element appears 1 cycle after its accept. sort_err=0.
- A={6,6 last}, B={6 last} -> out 6(A),6(A),6(B). out_last on the B element. sort_err=0.
- A={15 last}, B={3,8,11 last} -> 3,8,11 (B) then DRAIN_A emits 15 with out_last. Next packet A={0 last}, B={0 last} -> 0,0, no sort_err.
- Merge A={2,9 last}, B={3 last} with out_ready toggled 1,0,0,1,... -> out_data/out_last hold while stalled, no duplicates or drops, final sequence 2,3,9.
- A={5,2 last}, B={7 last} -> sort_err rises on the cycle 2 loads after 5 and stays 1. Then assert rst_n=0 asynchronously mid-packet -> outputs and sort_err go to 0 immediately, no out_last.
- b_valid held 0 while a_valid=1 in MERGE -> a_ready=0 and out_valid=0 until B presents data.
